// File: rtl/layernorm_row_stats_if.sv
// Row-statistics stream bundle: beat input side (data / data_valid_n / data_ready)
// and the held statistics output side with its active-low update pulse.
interface layernorm_row_stats_if #(
  parameter int INPUT_WIDTH  = 8,
  parameter int INPUT_NUM    = 768,
  parameter int LANES        = 16,
  parameter int SENTENCE_NUM = 128
);
  localparam int SUM_W  = INPUT_WIDTH + $clog2(INPUT_NUM);
  localparam int SQ_W   = 2*INPUT_WIDTH + $clog2(INPUT_NUM);
  localparam int RIDX_W = $clog2(SENTENCE_NUM);

  logic [INPUT_WIDTH*LANES-1:0]   data;
  logic                           data_valid_n;
  logic                           data_ready;
  logic signed [SUM_W-1:0]        sum;
  logic [SQ_W-1:0]                sumsq;
  logic signed [INPUT_WIDTH-1:0]  mean;
  logic [2*INPUT_WIDTH-1:0]       variance;
  logic [RIDX_W-1:0]              row_idx;
  logic                           stats_valid_n;

  modport master (
    output data, data_valid_n,
    input  data_ready, sum, sumsq, mean, variance, row_idx, stats_valid_n
  );

  modport slave (
    input  data, data_valid_n,
    output data_ready, sum, sumsq, mean, variance, row_idx, stats_valid_n
  );
endinterface

// File: rtl/layernorm_row_stats.sv
// Per-row sum / sum-of-squares accumulation followed by a shared 1-bit/cycle
// restoring divider producing floor mean and clamped variance for each row.
module layernorm_row_stats #(
  parameter int INPUT_WIDTH  = 8,
  parameter int INPUT_NUM    = 768,
  parameter int LANES        = 16,
  parameter int SENTENCE_NUM = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  layernorm_row_stats_if.slave  bus
);
  localparam int SUM_W  = INPUT_WIDTH + $clog2(INPUT_NUM);
  localparam int SQ_W   = 2*INPUT_WIDTH + $clog2(INPUT_NUM);
  localparam int BEATS  = INPUT_NUM / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RIDX_W = $clog2(SENTENCE_NUM);
  localparam int DCNT_W = $clog2(SQ_W + 1);

  localparam logic [SQ_W:0]       DIVISOR   = (SQ_W+1)'(INPUT_NUM);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [DCNT_W-1:0]   MEAN_LAST = DCNT_W'(SUM_W - 1);
  localparam logic [DCNT_W-1:0]   SQ_LAST   = DCNT_W'(SQ_W - 1);

  typedef enum logic [1:0] {ACCUM, DIV_MEAN, DIV_SQ, FINAL} state_t;

  state_t state, state_nxt;

  logic signed [SUM_W-1:0]         acc_sum;
  logic [SQ_W-1:0]                 acc_sq;
  logic [BEAT_W-1:0]               beat_cnt;
  logic [DCNT_W-1:0]               div_cnt;
  logic [SQ_W:0]                   rem;
  logic [SQ_W-1:0]                 quo;
  logic signed [INPUT_WIDTH-1:0]   mean_q;
  logic [RIDX_W-1:0]               row_cnt;

  logic signed [SUM_W-1:0]         sum_o;
  logic [SQ_W-1:0]                 sumsq_o;
  logic signed [INPUT_WIDTH-1:0]   mean_o;
  logic [2*INPUT_WIDTH-1:0]        var_o;
  logic [RIDX_W-1:0]               row_o;

  logic                            accept;
  logic                            data_ready;
  logic                            stats_valid_n;

  logic signed [INPUT_WIDTH-1:0]   lane;
  logic signed [2*INPUT_WIDTH-1:0] lane_sq;
  logic signed [SUM_W-1:0]         beat_sum;
  logic [SQ_W-1:0]                 beat_sq;
  logic signed [SUM_W-1:0]         sum_nxt;
  logic [SUM_W-1:0]                sum_abs;

  logic [SQ_W:0]                   rem_sh;
  logic                            q_bit;
  logic [SQ_W:0]                   rem_nxt;
  logic [SQ_W-1:0]                 quo_nxt;
  logic signed [SUM_W:0]           q_ext;
  logic signed [SUM_W:0]           mean_full;
  logic signed [2*INPUT_WIDTH-1:0] msq;
  logic signed [SQ_W:0]            d;
  logic [2*INPUT_WIDTH-1:0]        var_nxt;

  assign bus.data_ready    = data_ready;
  assign bus.stats_valid_n = stats_valid_n;
  assign bus.sum           = sum_o;
  assign bus.sumsq         = sumsq_o;
  assign bus.mean          = mean_o;
  assign bus.variance      = var_o;
  assign bus.row_idx       = row_o;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state: one pass per division, then a single FINAL cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:    if (accept && beat_cnt == LAST_BEAT) state_nxt = DIV_MEAN;
      DIV_MEAN: if (div_cnt == MEAN_LAST)            state_nxt = DIV_SQ;
      DIV_SQ:   if (div_cnt == SQ_LAST)              state_nxt = FINAL;
      FINAL:    state_nxt = ACCUM;
      default:  state_nxt = ACCUM;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    data_ready    = (state == ACCUM);
    stats_valid_n = (state != FINAL);
    accept        = (state == ACCUM) && !bus.data_valid_n;
  end

  // Lane reduction of the current beat
  always_comb begin
    lane     = '0;
    lane_sq  = '0;
    beat_sum = '0;
    beat_sq  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane     = $signed(bus.data[k*INPUT_WIDTH +: INPUT_WIDTH]);
      lane_sq  = lane * lane;
      beat_sum = beat_sum + SUM_W'(lane);
      beat_sq  = beat_sq + SQ_W'($unsigned(lane_sq));
    end
    sum_nxt = acc_sum + beat_sum;
    sum_abs = sum_nxt[SUM_W-1] ? SUM_W'(-sum_nxt) : SUM_W'(sum_nxt);
  end

  // Restoring divider step plus mean sign fix-up and variance clamp
  always_comb begin
    rem_sh  = (SQ_W+1)'({rem, quo[SQ_W-1]});
    q_bit   = (rem_sh >= DIVISOR);
    rem_nxt = q_bit ? (rem_sh - DIVISOR) : rem_sh;
    quo_nxt = {quo[SQ_W-2:0], q_bit};
    q_ext   = $signed({1'b0, quo_nxt[SUM_W-1:0]});
    // Magnitude division truncates toward zero; negative sums with a
    // non-zero remainder need one more step down to reach the floor.
    if (acc_sum[SUM_W-1])
      mean_full = (rem_nxt == '0) ? -q_ext : (-q_ext - (SUM_W+1)'(1));
    else
      mean_full = q_ext;
    msq     = mean_q * mean_q;
    d       = $signed({1'b0, quo}) - (SQ_W+1)'(msq);
    var_nxt = (d < 0) ? '0 : (2*INPUT_WIDTH)'(d);
  end

  // Accumulators, divider registers and held result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum  <= '0;
      acc_sq   <= '0;
      beat_cnt <= '0;
      div_cnt  <= '0;
      rem      <= '0;
      quo      <= '0;
      mean_q   <= '0;
      row_cnt  <= '0;
      sum_o    <= '0;
      sumsq_o  <= '0;
      mean_o   <= '0;
      var_o    <= '0;
      row_o    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_sum <= sum_nxt;
            acc_sq  <= acc_sq + beat_sq;
            if (beat_cnt == LAST_BEAT) begin
              // Divider is loaded on the last-beat edge so the mean pass
              // starts in the very next cycle; the dividend sits in the top
              // bits so SUM_W steps leave the quotient in the low bits.
              beat_cnt <= '0;
              div_cnt  <= '0;
              rem      <= '0;
              quo      <= SQ_W'(sum_abs) << (SQ_W - SUM_W);
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        DIV_MEAN: begin
          if (div_cnt == MEAN_LAST) begin
            mean_q  <= INPUT_WIDTH'(mean_full);
            div_cnt <= '0;
            rem     <= '0;
            quo     <= acc_sq;
          end else begin
            div_cnt <= div_cnt + DCNT_W'(1);
            rem     <= rem_nxt;
            quo     <= quo_nxt;
          end
        end
        DIV_SQ: begin
          div_cnt <= div_cnt + DCNT_W'(1);
          rem     <= rem_nxt;
          quo     <= quo_nxt;
        end
        FINAL: begin
          sum_o   <= acc_sum;
          sumsq_o <= acc_sq;
          mean_o  <= mean_q;
          var_o   <= var_nxt;
          row_o   <= row_cnt;
          row_cnt <= row_cnt + RIDX_W'(1);
          acc_sum <= '0;
          acc_sq  <= '0;
          div_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_layernorm_row_stats.sv
// Bench for layernorm_row_stats: directed row table, abort/bubble sequences
// and a long back-to-back random run against an arithmetic reference.
module tb_layernorm_row_stats;
  localparam int IW     = 8;
  localparam int N      = 768;
  localparam int L      = 16;
  localparam int SN     = 128;
  localparam int BEATS  = N / L;
  localparam int LAT    = 45;
  localparam int PERIOD = 93;

  localparam int K_ONE = 0, K_ALT = 1, K_NEG = 2, K_TWO = 3, K_MIN = 4, K_MAX = 5, K_RND = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layernorm_row_stats_if #(.INPUT_WIDTH(IW), .INPUT_NUM(N), .LANES(L), .SENTENCE_NUM(SN)) bus ();

  layernorm_row_stats #(.INPUT_WIDTH(IW), .INPUT_NUM(N), .LANES(L), .SENTENCE_NUM(SN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int s; int sq; int m; int v; int ri;} res_t;
  typedef struct {int kind; int e_s; int e_sq; int e_m; int e_v;} vec_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  int     row_buf[N];
  res_t   got_q[$];
  longint pulse_q[$];
  bit     prev_low = 1'b0;
  int     long_pulse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs become valid in the cycle after the low pulse
  always @(negedge clk) begin
    res_t r;
    if (prev_low) begin
      r.s  = int'(bus.sum);
      r.sq = int'(bus.sumsq);
      r.m  = int'(bus.mean);
      r.v  = int'(bus.variance);
      r.ri = int'(bus.row_idx);
      got_q.push_back(r);
    end
    if (bus.stats_valid_n === 1'b0) begin
      pulse_q.push_back(cyc);
      if (prev_low) long_pulse++;
    end
    prev_low = (bus.stats_valid_n === 1'b0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic res_t model(input int ri);
    res_t r;
    longint s = 0, sq = 0, m, q, v;
    for (int i = 0; i < N; i++) begin
      s  += row_buf[i];
      sq += row_buf[i] * row_buf[i];
    end
    m = s / N;
    if ((s % N) != 0 && s < 0) m = m - 1;
    q = sq / N;
    v = q - m * m;
    if (v < 0) v = 0;
    r.s = int'(s); r.sq = int'(sq); r.m = int'(m); r.v = int'(v); r.ri = ri;
    return r;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        K_ONE:   row_buf[i] = 1;
        K_ALT:   row_buf[i] = ((i % L) % 2 == 0) ? -128 : 127;
        K_NEG:   row_buf[i] = (i == 300) ? 0 : -1;
        K_TWO:   row_buf[i] = 2;
        K_MIN:   row_buf[i] = -128;
        K_MAX:   row_buf[i] = 127;
        default: row_buf[i] = int'($urandom_range(255)) - 128;
      endcase
    end
  endtask

  // Entered and left on a negedge; last beat stays driven on exit
  task automatic send_row(input int nbeats, input int bubble_pct, output longint last_edge);
    logic [IW*L-1:0] d;
    int guard;
    last_edge = 0;
    for (int b = 0; b < nbeats; b++) begin
      while (int'($urandom_range(99)) < bubble_pct) begin
        bus.data_valid_n = 1'b1;
        @(negedge clk);
      end
      for (int k = 0; k < L; k++) d[k*IW +: IW] = IW'(row_buf[b*L + k]);
      bus.data         = d;
      bus.data_valid_n = 1'b0;
      guard = 0;
      while (bus.data_ready !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        $display("FAIL send_ready_timeout: got data_ready low for %0d cycles, expected below 200", guard);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
        $fatal(1);
      end
      last_edge = cyc + 1;
      @(negedge clk);
    end
  endtask

  // Holds the last beat on the bus while not ready, releases it once ready
  task automatic stall_release(output int n);
    n = 0;
    while (bus.data_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    bus.data_valid_n = 1'b1;
  endtask

  task automatic wait_result(input string tag, output res_t r, output bit ok);
    int guard = 0;
    while (got_q.size() == 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (got_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no stats pulse, expected one within 300 cycles", tag);
      ok = 1'b0;
      r  = '{0, 0, 0, 0, 0};
    end else begin
      r  = got_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic compare_res(input string tag, input res_t g, input res_t e);
    check({tag, "_sum"},     g.s,  e.s);
    check({tag, "_sumsq"},   g.sq, e.sq);
    check({tag, "_mean"},    g.m,  e.m);
    check({tag, "_var"},     g.v,  e.v);
    check({tag, "_row_idx"}, g.ri, e.ri);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.data_valid_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vec_t   vecs[6];
    res_t   g, e, held[$];
    bit     ok;
    longint le;
    int     n, pb, gb;

    vecs[0] = '{K_ONE,    768,      768,    1,     0};
    vecs[1] = '{K_ALT,   -384, 12484992,   -1, 16255};
    vecs[2] = '{K_NEG,   -767,      767,   -1,     0};
    vecs[3] = '{K_TWO,   1536,     3072,    2,     0};
    vecs[4] = '{K_MIN, -98304, 12582912, -128,     0};
    vecs[5] = '{K_MAX,  97536, 12387072,  127,     0};

    rst = 1'b1;
    bus.data = '0;
    bus.data_valid_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_ready",    bus.data_ready,    1);
    check("rst_stats_valid_n", bus.stats_valid_n, 1);
    check("rst_sum",           int'(bus.sum),     0);
    check("rst_sumsq",         bus.sumsq,         0);
    check("rst_mean",          int'(bus.mean),    0);
    check("rst_var",           bus.variance,      0);
    check("rst_row_idx",       bus.row_idx,       0);
    rst = 1'b0;
    @(negedge clk);

    // Directed rows with fixed expected statistics
    for (int i = 0; i < 6; i++) begin
      fill(vecs[i].kind);
      pb = pulse_q.size();
      send_row(BEATS, 0, le);
      stall_release(n);
      check($sformatf("vec%0d_stall_cycles", i), n, LAT);
      wait_result($sformatf("vec%0d", i), g, ok);
      if (ok) begin
        e = '{vecs[i].e_s, vecs[i].e_sq, vecs[i].e_m, vecs[i].e_v, i};
        compare_res($sformatf("vec%0d", i), g, e);
        check($sformatf("vec%0d_latency", i),
              (pulse_q.size() > pb) ? (pulse_q[pb] - le + 1) : -1, LAT);
      end
    end

    // Reset part-way through a row: no pulse, row index restarts
    fill(K_TWO);
    gb = got_q.size();
    pb = pulse_q.size();
    send_row(20, 0, le);
    do_reset();
    repeat (60) @(negedge clk);
    check("abort_pulses", (got_q.size() - gb) + (pulse_q.size() - pb), 0);
    send_row(BEATS, 0, le);
    stall_release(n);
    check("abort_next_stall_cycles", n, LAT);
    wait_result("abort_next", g, ok);
    if (ok) compare_res("abort_next", g, '{1536, 3072, 2, 0, 0});

    // Same random row gap-free and with input bubbles
    fill(K_RND);
    e = model(1);
    send_row(BEATS, 0, le);
    stall_release(n);
    wait_result("nobubble", g, ok);
    if (ok) compare_res("nobubble", g, e);
    e.ri = 2;
    send_row(BEATS, 40, le);
    stall_release(n);
    check("bubble_stall_cycles", n, LAT);
    wait_result("bubble", g, ok);
    if (ok) compare_res("bubble", g, e);

    // Back-to-back random rows across the row index wrap
    do_reset();
    while (got_q.size() > 0) void'(got_q.pop_front());
    pb = pulse_q.size();
    for (int r = 0; r < SN + 1; r++) begin
      fill(K_RND);
      held.push_back(model(r % SN));
      send_row(BEATS, 0, le);
    end
    stall_release(n);
    for (int r = 0; r < SN + 1; r++) begin
      wait_result($sformatf("rnd%0d", r), g, ok);
      if (!ok) break;
      compare_res($sformatf("rnd%0d", r), g, held[r]);
    end
    for (int r = 1; r < SN + 1; r++) begin
      check($sformatf("rnd_spacing%0d", r),
            (pulse_q.size() > pb + r) ? (pulse_q[pb + r] - pulse_q[pb + r - 1]) : -1, PERIOD);
    end
    check("pulse_width_overruns", long_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
